hsid_sq_df_acc: RTL and testbench
=================================

HSID_SQ_DF_ACC -- requirements
Module: hsid_sq_df_acc

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default HSID_WORD_WIDTH, giving the bits per band sample.
REQ-002 The block SHALL have parameter HSP_BANDS_WIDTH, default HSID_HSP_BANDS_WIDTH, giving the band-count width.
REQ-003 The block SHALL have parameter HSP_LIBRARY_WIDTH, default HSID_HSP_LIBRARY_WIDTH, giving the reference-index width.
REQ-004 The block SHALL have parameter ACC_WIDTH, default 2*WORD_WIDTH+HSP_BANDS_WIDTH, giving the accumulator width.
REQ-005 The block SHALL have these ports: clk in 1, sole clock, rising edge; rst_n in 1, asynchronous active-low reset.
REQ-006 The block SHALL have these ports: clear in 1, synchronous flush; hsp_bands in HSP_BANDS_WIDTH, configured band count, stable during a run.
REQ-007 The block SHALL have these ports: band_pack_valid in 1; band_pack_start in 1, first pack of a vector; band_pack_last in 1, last pack of a vector.
REQ-008 The block SHALL have these ports: captured_pack in 2*WORD_WIDTH; ref_pack in 2*WORD_WIDTH. In both, lane0 [WORD_WIDTH-1:0] is band 2i and lane1 [2*WORD_WIDTH-1:WORD_WIDTH] is band 2i+1.
REQ-009 The block SHALL have these ports: acc_valid out 1; acc_value out ACC_WIDTH, sum of squared differences; acc_ref_index out HSP_LIBRARY_WIDTH; acc_overflow out 1.

Function
REQ-010 Samples SHALL be treated as unsigned, and each lane difference SHALL be |captured-ref|, WORD_WIDTH bits.
REQ-011 Pipeline: S1 registers the lane absolute differences. S2 registers the lane squares, 2*WORD_WIDTH bits each. S3 registers the lane0+lane1 sum, 2*WORD_WIDTH+1 bits. S4 is the accumulator register.
REQ-012 valid, start and last SHALL travel with the data through S1-S3 with no bubbles, accepting one pack per cycle, with no backpressure.
REQ-013 When band_pack_last=1 and hsp_bands[0]=1, the lane1 difference of that pack SHALL be forced to 0.
REQ-014 At S4 with valid and start, acc SHALL load the S3 sum, discarding any prior partial sum. At S4 with valid and not start, acc SHALL add the S3 sum.
REQ-015 start and last asserted on the same pack SHALL produce a single-pack result.
REQ-016 For a pack with last, acc_valid SHALL pulse for 1 cycle exactly 4 cycles after the input cycle, with acc_value holding that vector's final sum.
REQ-017 acc_value SHALL hold its value until the next acc_valid, clear or reset.
REQ-018 acc_ref_index SHALL equal the number of vectors completed since clear/reset, before the current one. It increments after each acc_valid and wraps from all-ones to 0.
REQ-019 A valid pack arriving before any start SHALL accumulate onto the current acc, which is 0 after reset or clear.
REQ-020 clear SHALL, on the next edge, drop all in-flight valids, zero acc, acc_value, acc_ref_index and acc_overflow, and deassert acc_valid.
REQ-021 clear SHALL dominate any band_pack_valid in the same cycle, so that pack is discarded.
REQ-022 band_pack_start, band_pack_last and the pack inputs SHALL be ignored when band_pack_valid=0.

Reset
REQ-023 While rst_n=0, all pipeline registers, acc, acc_value, acc_ref_index, acc_valid and acc_overflow SHALL be 0, asynchronously.
REQ-024 The first pack SHALL be accepted at the first rising edge after rst_n deasserts.
REQ-025 Reset mid-vector SHALL lose that vector with no acc_valid produced.

Configuration
REQ-026 With macro HSID_SQ_DF_ACC_SATURATE_EN defined, an S4 add that would exceed 2^ACC_WIDTH-1 SHALL clamp acc to all-ones and set a sticky overflow bit for the vector. acc_overflow SHALL equal that bit while acc_valid=1, and the bit SHALL clear on the next start.
REQ-027 Without HSID_SQ_DF_ACC_SATURATE_EN, acc SHALL wrap modulo 2^ACC_WIDTH and acc_overflow SHALL be tied to 0.

Verification
REQ-028 WORD_WIDTH=16, hsp_bands=4, two packs, all lanes with captured=10 and ref=7 -> acc_valid 4 cycles after the last pack, acc_value=36, acc_ref_index=0.
REQ-029 hsp_bands=3, packs {c=5,r=2 | c=1,r=1} then {c=9,r=4 | c=100,r=0} -> acc_value=34, with lane1 of the last pack masked.
REQ-030 Back-to-back vectors with start following last in consecutive cycles, results 8 then 50 -> two acc_valid pulses 2 cycles apart, acc_ref_index 0 then 1.
REQ-031 clear asserted 2 cycles after a last pack -> no acc_valid, and acc_value=0 and acc_ref_index=0 the next cycle.
REQ-032 ACC_WIDTH=8, single pack with c=255, r=0 in both lanes -> with HSID_SQ_DF_ACC_SATURATE_EN, acc_value=255 and acc_overflow=1; without it, acc_value=(2*65025) mod 256=2 and acc_overflow=0.
REQ-033 rst_n pulsed low mid-vector -> outputs 0 immediately, and no acc_valid for the interrupted vector.

Source files
------------

// File: rtl/hsid_sq_df_acc.sv
// Pipelined sum-of-squared-differences accumulator over two-band sample packs.
// Define HSID_SQ_DF_ACC_SATURATE_EN to clamp the accumulator and report overflow.
`ifndef HSID_WORD_WIDTH
`define HSID_WORD_WIDTH 16
`endif
`ifndef HSID_HSP_BANDS_WIDTH
`define HSID_HSP_BANDS_WIDTH 8
`endif
`ifndef HSID_HSP_LIBRARY_WIDTH
`define HSID_HSP_LIBRARY_WIDTH 8
`endif

module hsid_sq_df_acc #(
  parameter int unsigned WORD_WIDTH        = `HSID_WORD_WIDTH,
  parameter int unsigned HSP_BANDS_WIDTH   = `HSID_HSP_BANDS_WIDTH,
  parameter int unsigned HSP_LIBRARY_WIDTH = `HSID_HSP_LIBRARY_WIDTH,
  parameter int unsigned ACC_WIDTH         = 2*WORD_WIDTH+HSP_BANDS_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
  input  logic                         band_pack_valid,
  input  logic                         band_pack_start,
  input  logic                         band_pack_last,
  input  logic [2*WORD_WIDTH-1:0]      captured_pack,
  input  logic [2*WORD_WIDTH-1:0]      ref_pack,
  output logic                         acc_valid,
  output logic [ACC_WIDTH-1:0]         acc_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] acc_ref_index,
  output logic                         acc_overflow
);

  localparam int unsigned SqW  = 2*WORD_WIDTH;
  localparam int unsigned SumW = 2*WORD_WIDTH+1;
  localparam int unsigned ExtW = ((ACC_WIDTH > SumW) ? ACC_WIDTH : SumW) + 1;

  logic [WORD_WIDTH-1:0] cap0, cap1, ref0, ref1, diff0_d, diff1_d;
  logic                  mask_lane1;

  logic                  s1_valid_q, s1_start_q, s1_last_q;
  logic [WORD_WIDTH-1:0] s1_diff0_q, s1_diff1_q;
  logic                  s2_valid_q, s2_start_q, s2_last_q;
  logic [SqW-1:0]        s2_sq0_q, s2_sq1_q;
  logic                  s3_valid_q, s3_start_q, s3_last_q;
  logic [SumW-1:0]       s3_sum_q;

  logic [ACC_WIDTH-1:0]         acc_q, acc_d, acc_value_q;
  logic                         acc_valid_q;
  logic [HSP_LIBRARY_WIDTH-1:0] ref_index_q;
  logic [ExtW-1:0]              acc_base, acc_total;
  logic                         vec_done;
  logic                         unused_bands;

  assign unused_bands = ^hsp_bands;

  assign cap0 = captured_pack[WORD_WIDTH-1:0];
  assign cap1 = captured_pack[2*WORD_WIDTH-1:WORD_WIDTH];
  assign ref0 = ref_pack[WORD_WIDTH-1:0];
  assign ref1 = ref_pack[2*WORD_WIDTH-1:WORD_WIDTH];

  // An odd band count leaves lane1 of the final pack without a real band.
  assign mask_lane1 = band_pack_last & hsp_bands[0];

  always_comb begin
    diff0_d = (cap0 >= ref0) ? (cap0 - ref0) : (ref0 - cap0);
    diff1_d = (cap1 >= ref1) ? (cap1 - ref1) : (ref1 - cap1);
    if (mask_lane1) begin
      diff1_d = '0;
    end
  end

  assign vec_done = s3_valid_q & s3_last_q;

  // A start pack loads rather than adds, so its base is zero.
  always_comb begin
    acc_base  = s3_start_q ? '0 : ExtW'(acc_q);
    acc_total = acc_base + ExtW'(s3_sum_q);
  end

`ifdef HSID_SQ_DF_ACC_SATURATE_EN
  logic ovf_q, ovf_d, acc_overflow_q, total_hi;

  assign total_hi = |acc_total[ExtW-1:ACC_WIDTH];

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (s3_valid_q) begin
      ovf_d = (s3_start_q ? 1'b0 : ovf_q) | total_hi;
      acc_d = total_hi ? '1 : acc_total[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q          <= 1'b0;
      acc_overflow_q <= 1'b0;
    end else if (clear) begin
      ovf_q          <= 1'b0;
      acc_overflow_q <= 1'b0;
    end else begin
      ovf_q          <= ovf_d;
      acc_overflow_q <= vec_done ? ovf_d : 1'b0;
    end
  end

  assign acc_overflow = acc_overflow_q;
`else
  logic unused_total_hi;

  assign unused_total_hi = ^acc_total[ExtW-1:ACC_WIDTH];

  always_comb begin
    acc_d = acc_q;
    if (s3_valid_q) begin
      acc_d = acc_total[ACC_WIDTH-1:0];
    end
  end

  assign acc_overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_start_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_diff0_q  <= '0;
      s1_diff1_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_start_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sq0_q    <= '0;
      s2_sq1_q    <= '0;
      s3_valid_q  <= 1'b0;
      s3_start_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_sum_q    <= '0;
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      acc_value_q <= '0;
      ref_index_q <= '0;
    end else if (clear) begin
      s1_valid_q  <= 1'b0;
      s1_start_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_diff0_q  <= '0;
      s1_diff1_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_start_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sq0_q    <= '0;
      s2_sq1_q    <= '0;
      s3_valid_q  <= 1'b0;
      s3_start_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_sum_q    <= '0;
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      acc_value_q <= '0;
      ref_index_q <= '0;
    end else begin
      s1_valid_q  <= band_pack_valid;
      s1_start_q  <= band_pack_valid & band_pack_start;
      s1_last_q   <= band_pack_valid & band_pack_last;
      s1_diff0_q  <= diff0_d;
      s1_diff1_q  <= diff1_d;
      s2_valid_q  <= s1_valid_q;
      s2_start_q  <= s1_start_q;
      s2_last_q   <= s1_last_q;
      s2_sq0_q    <= SqW'(s1_diff0_q) * SqW'(s1_diff0_q);
      s2_sq1_q    <= SqW'(s1_diff1_q) * SqW'(s1_diff1_q);
      s3_valid_q  <= s2_valid_q;
      s3_start_q  <= s2_start_q;
      s3_last_q   <= s2_last_q;
      s3_sum_q    <= SumW'(s2_sq0_q) + SumW'(s2_sq1_q);
      acc_q       <= acc_d;
      acc_valid_q <= vec_done;
      if (vec_done) begin
        acc_value_q <= acc_d;
      end
      // Index advances only after the pulse so it names the vector being reported.
      if (acc_valid_q) begin
        ref_index_q <= ref_index_q + 1'b1;
      end
    end
  end

  assign acc_valid     = acc_valid_q;
  assign acc_value     = acc_value_q;
  assign acc_ref_index = ref_index_q;

endmodule

// File: tb/tb_hsid_sq_df_acc.sv
// Self-checking bench for hsid_sq_df_acc: directed cases plus random vectors vs a band-level model.
module tb_hsid_sq_df_acc;
  localparam int unsigned W  = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned LW = 8;
  localparam int unsigned AW = 2*W+BW;
  localparam longint unsigned AMASK = (64'd1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, clear, v, s, l;
  logic [BW-1:0] hsp;
  logic [2*W-1:0] cp, rp;
  logic          acc_valid, acc_ovf, n_valid, n_ovf;
  logic [AW-1:0] acc_value;
  logic [LW-1:0] acc_idx, n_idx;
  logic [7:0]    n_value;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {bit fire; longint unsigned val;} ev_t;
  ev_t pipe[$];
  longint unsigned m_acc, m_held;
  int unsigned     m_count;

  always #5 clk = ~clk;

  hsid_sq_df_acc #(.WORD_WIDTH(W), .HSP_BANDS_WIDTH(BW), .HSP_LIBRARY_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .hsp_bands(hsp),
    .band_pack_valid(v), .band_pack_start(s), .band_pack_last(l),
    .captured_pack(cp), .ref_pack(rp),
    .acc_valid(acc_valid), .acc_value(acc_value), .acc_ref_index(acc_idx),
    .acc_overflow(acc_ovf)
  );

  hsid_sq_df_acc #(.WORD_WIDTH(W), .HSP_BANDS_WIDTH(BW), .HSP_LIBRARY_WIDTH(LW),
                   .ACC_WIDTH(8)) dut_n (
    .clk(clk), .rst_n(rst_n), .clear(clear), .hsp_bands(hsp),
    .band_pack_valid(v), .band_pack_start(s), .band_pack_last(l),
    .captured_pack(cp), .ref_pack(rp),
    .acc_valid(n_valid), .acc_value(n_value), .acc_ref_index(n_idx),
    .acc_overflow(n_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned pack_sq(input logic [2*W-1:0] c, input logic [2*W-1:0] r,
                                              input bit mask1);
    longint unsigned d0, d1;
    d0 = (c[W-1:0] >= r[W-1:0]) ? c[W-1:0] - r[W-1:0] : r[W-1:0] - c[W-1:0];
    d1 = (c[2*W-1:W] >= r[2*W-1:W]) ? c[2*W-1:W] - r[2*W-1:W] : r[2*W-1:W] - c[2*W-1:W];
    if (mask1) d1 = 0;
    return d0*d0 + d1*d1;
  endfunction

  task automatic flush();
    ev_t e;
    e.fire = 0;
    e.val  = 0;
    pipe.delete();
    repeat (3) pipe.push_back(e);
    m_acc = 0;
    m_held = 0;
    m_count = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(acc_valid), 64'd0);
    chk({tag, "_value"}, 64'(acc_value), 64'd0);
    chk({tag, "_index"}, 64'(acc_idx), 64'd0);
    chk({tag, "_ovf"}, 64'(acc_ovf), 64'd0);
  endtask

  // One clock cycle: drive, clock, then compare against the model.
  task automatic cyc(input bit iv, input bit is, input bit il, input logic [2*W-1:0] ic,
                     input logic [2*W-1:0] ir, input bit iclr);
    ev_t e;
    clear = iclr; v = iv; s = is; l = il; cp = ic; rp = ir;
    @(posedge clk);
    #1;
    if (iclr) begin
      flush();
      chk_zero("clear");
    end else begin
      e.fire = 0;
      e.val  = 0;
      if (iv) begin
        longint unsigned sq;
        sq = pack_sq(ic, ir, il && hsp[0]);
        m_acc = is ? sq : ((m_acc + sq) & AMASK);
        e.fire = il;
        e.val  = m_acc;
      end
      pipe.push_back(e);
      e = pipe.pop_front();
      if (e.fire) m_held = e.val;
      chk("valid", 64'(acc_valid), 64'(e.fire));
      chk("value", 64'(acc_value), m_held);
      chk("index", 64'(acc_idx), 64'(m_count % (1 << LW)));
      chk("ovf", 64'(acc_ovf), 64'd0);
      if (e.fire) m_count++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 0);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_zero(tag);
    chk({tag, "_nvalue"}, 64'(n_value), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    flush();
  endtask

  initial begin
    rst_n = 1'b0; clear = 0; v = 0; s = 0; l = 0; cp = '0; rp = '0; hsp = 8'd4;
    flush();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Four bands of 10 vs 7, two packs: 4 * 9.
    hsp = 8'd4;
    cyc(1, 1, 0, {16'd10, 16'd10}, {16'd7, 16'd7}, 0);
    cyc(1, 0, 1, {16'd10, 16'd10}, {16'd7, 16'd7}, 0);
    idle(3);
    chk("r028_valid", 64'(acc_valid), 64'd1);
    chk("r028_value", 64'(acc_value), 64'd36);
    chk("r028_index", 64'(acc_idx), 64'd0);

    // Three bands: lane1 of the last pack is masked, 9 + 0 + 25.
    hsp = 8'd3;
    cyc(1, 1, 0, {16'd1, 16'd5}, {16'd1, 16'd2}, 0);
    cyc(1, 0, 1, {16'd100, 16'd9}, {16'd0, 16'd4}, 0);
    idle(3);
    chk("r029_value", 64'(acc_value), 64'd34);
    chk("r029_index", 64'(acc_idx), 64'd1);

    // Back-to-back vectors after a clear.
    cyc(0, 0, 0, '0, '0, 1);
    hsp = 8'd4;
    cyc(1, 1, 1, {16'd2, 16'd2}, {16'd0, 16'd0}, 0);
    cyc(1, 1, 0, {16'd5, 16'd5}, {16'd0, 16'd0}, 0);
    cyc(1, 0, 1, {16'd0, 16'd0}, {16'd0, 16'd0}, 0);
    idle(1);
    chk("r030_a_valid", 64'(acc_valid), 64'd1);
    chk("r030_a_value", 64'(acc_value), 64'd8);
    chk("r030_a_index", 64'(acc_idx), 64'd0);
    idle(1);
    chk("r030_gap", 64'(acc_valid), 64'd0);
    idle(1);
    chk("r030_b_valid", 64'(acc_valid), 64'd1);
    chk("r030_b_value", 64'(acc_value), 64'd50);
    chk("r030_b_index", 64'(acc_idx), 64'd1);
    idle(2);

    // Clear two cycles after a last pack swallows the result.
    cyc(1, 1, 1, {16'd0, 16'd3}, {16'd0, 16'd0}, 0);
    idle(1);
    cyc(1, 1, 1, {16'd9, 16'd9}, {16'd0, 16'd0}, 1);
    idle(1);
    chk("r031_valid", 64'(acc_valid), 64'd0);
    chk("r031_value", 64'(acc_value), 64'd0);
    chk("r031_index", 64'(acc_idx), 64'd0);
    idle(3);

    // A pack with no preceding start accumulates onto the cleared acc.
    cyc(1, 0, 1, {16'd0, 16'd4}, {16'd0, 16'd0}, 0);
    idle(3);
    chk("r019_value", 64'(acc_value), 64'd16);

    // Narrow accumulator: 2 * 65025 overflows 8 bits.
    cyc(0, 0, 0, '0, '0, 1);
    cyc(1, 1, 1, {16'd255, 16'd255}, {16'd0, 16'd0}, 0);
    idle(3);
    chk("r032_valid", 64'(n_valid), 64'd1);
`ifdef HSID_SQ_DF_ACC_SATURATE_EN
    chk("r032_value", 64'(n_value), 64'd255);
    chk("r032_ovf", 64'(n_ovf), 64'd1);
`else
    chk("r032_value", 64'(n_value), 64'd2);
    chk("r032_ovf", 64'(n_ovf), 64'd0);
`endif
    idle(1);

    // Reset with the vector still in flight.
    cyc(1, 1, 0, {16'd7, 16'd7}, {16'd1, 16'd1}, 0);
    cyc(1, 0, 1, {16'd7, 16'd7}, {16'd1, 16'd1}, 0);
    idle(1);
    do_reset("r033");
    idle(6);

    // Random vectors with idle gaps and occasional clears.
    for (int n = 0; n < 40; n++) begin
      int b, packs;
      b = $urandom_range(1, 12);
      hsp = BW'(b);
      packs = (b + 1) / 2;
      for (int p = 0; p < packs; p++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        cyc(1, p == 0, p == packs - 1, $urandom, $urandom, 0);
      end
      if ($urandom_range(0, 9) == 0) begin
        cyc(1'($urandom_range(0, 1)), 1, 1, $urandom, $urandom, 1);
      end
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
